// File: rtl/sensor_bus_pkg.sv
// Shared types and constants for the SPI/I2C shared sensor bus arbiter.
// Holds the FSM state enum, owner encodings, pin bundle struct and idle pin levels.
package sensor_bus_pkg;

  localparam int unsigned GAP_CNT_W  = 8;
  localparam int unsigned HOLD_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPI_OWN = 2'd1,
    ST_I2C_OWN = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  typedef logic [1:0] owner_t;
  localparam owner_t OWNER_NONE = 2'b00;
  localparam owner_t OWNER_SPI  = 2'b01;
  localparam owner_t OWNER_I2C  = 2'b10;

  // One master's (or the bus's) view of the two-wire pin pair plus chip select
  typedef struct packed {
    logic sclk;
    logic cs_n;
    logic sdat_out;
    logic sdat_oe;
  } pins_t;

  // Idle levels that are safe for both I2C and SPI mode 3
  localparam logic IDLE_SCLK     = 1'b1;
  localparam logic IDLE_CS_N     = 1'b1;
  localparam logic IDLE_SDAT_OUT = 1'b1;
  localparam logic IDLE_SDAT_OE  = 1'b0;

  localparam pins_t IDLE_PINS = '{
    sclk:     IDLE_SCLK,
    cs_n:     IDLE_CS_N,
    sdat_out: IDLE_SDAT_OUT,
    sdat_oe:  IDLE_SDAT_OE
  };

endpackage

// File: rtl/shared_sensor_bus_arbiter_if.sv
// Handshake and pin signals between the two masters, the arbiter and the pins.
// slave modport: the arbiter's view; master modport: the masters/pins side.
interface shared_sensor_bus_arbiter_if;
  import sensor_bus_pkg::*;

  logic   spi_req;
  logic   i2c_req;
  logic   spi_done;
  logic   i2c_done;
  logic   spi_gnt;
  logic   i2c_gnt;
  logic   spi_sclk;
  logic   spi_cs_n;
  logic   spi_sdo;
  logic   spi_sdo_oe;
  logic   i2c_scl;
  logic   i2c_sda_out;
  logic   i2c_sda_oe;
  logic   spi_sdi;
  logic   i2c_sda_in;
  logic   bus_sclk;
  logic   bus_cs_n;
  logic   bus_sdat_out;
  logic   bus_sdat_oe;
  logic   bus_sdat_in;
  owner_t owner;
  logic   timeout_err;

  modport slave (
    input  spi_req, i2c_req, spi_done, i2c_done,
    input  spi_sclk, spi_cs_n, spi_sdo, spi_sdo_oe,
    input  i2c_scl, i2c_sda_out, i2c_sda_oe,
    input  bus_sdat_in,
    output spi_gnt, i2c_gnt, spi_sdi, i2c_sda_in,
    output bus_sclk, bus_cs_n, bus_sdat_out, bus_sdat_oe,
    output owner, timeout_err
  );

  modport master (
    output spi_req, i2c_req, spi_done, i2c_done,
    output spi_sclk, spi_cs_n, spi_sdo, spi_sdo_oe,
    output i2c_scl, i2c_sda_out, i2c_sda_oe,
    output bus_sdat_in,
    input  spi_gnt, i2c_gnt, spi_sdi, i2c_sda_in,
    input  bus_sclk, bus_cs_n, bus_sdat_out, bus_sdat_oe,
    input  owner, timeout_err
  );

endinterface

// File: rtl/sensor_bus_pin_mux.sv
// Combinational pin mux: routes the owning master's pin intent to the bus,
// idle levels otherwise.
// Ports: owner (registered owner code), spi_pins / i2c_pins (master intents),
// bus_pins (to the physical pins).
module sensor_bus_pin_mux
  import sensor_bus_pkg::*;
(
  input  owner_t owner,
  input  pins_t  spi_pins,
  input  pins_t  i2c_pins,
  output pins_t  bus_pins
);

  always_comb begin
    bus_pins = IDLE_PINS;
    case (owner)
      OWNER_SPI: bus_pins = spi_pins;
      OWNER_I2C: bus_pins = i2c_pins;
      default:   bus_pins = IDLE_PINS;
    endcase
  end

endmodule

// File: rtl/shared_sensor_bus_arbiter.sv
// Request/grant arbiter for the shared SCLK/SDAT pin pair between the G-sensor
// SPI master and the I2C master: round-robin on contention, ownership changes
// only at transaction end, an enforced idle gap, and a hold timeout.
// Ports: sys_clk, reset (async, active high); sb (slave modport) carrying
// requests/dones/grants, both masters' pin intents, bus pins, owner, timeout_err.
module shared_sensor_bus_arbiter
  import sensor_bus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                         sys_clk,
  input logic                         reset,
  shared_sensor_bus_arbiter_if.slave  sb
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                  state, state_nxt;
  owner_t                  owner_q, owner_nxt;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic [GAP_CNT_W-1:0]    gap_cnt;
  logic                    last_i2c;
  logic                    spi_gnt_q, i2c_gnt_q, timeout_err_q;
  logic                    timeout_hit;
  pins_t                   spi_pins, i2c_pins, bus_pins;

  // Next-state: grant from IDLE, release from OWN, wait out the gap
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    owner_nxt   = OWNER_NONE;
    case (state)
      ST_IDLE: begin
        if (sb.spi_req && sb.i2c_req) begin
          state_nxt = last_i2c ? ST_SPI_OWN : ST_I2C_OWN;
        end else if (sb.spi_req) begin
          state_nxt = ST_SPI_OWN;
        end else if (sb.i2c_req) begin
          state_nxt = ST_I2C_OWN;
        end
      end
      // A normal release (done or req dropped) wins over a coincident timeout
      ST_SPI_OWN: begin
        if (sb.spi_done || !sb.spi_req) begin
          state_nxt = ST_GAP;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = ST_GAP;
          timeout_hit = 1'b1;
        end
      end
      ST_I2C_OWN: begin
        if (sb.i2c_done || !sb.i2c_req) begin
          state_nxt = ST_GAP;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = ST_GAP;
          timeout_hit = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_SPI_OWN: owner_nxt = OWNER_SPI;
      ST_I2C_OWN: owner_nxt = OWNER_I2C;
      default:    owner_nxt = OWNER_NONE;
    endcase
  end

  // State, counters, round-robin bit and registered outputs
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      last_i2c      <= 1'b1;
      spi_gnt_q     <= 1'b0;
      i2c_gnt_q     <= 1'b0;
      owner_q       <= OWNER_NONE;
      timeout_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      spi_gnt_q <= (state_nxt == ST_SPI_OWN);
      i2c_gnt_q <= (state_nxt == ST_I2C_OWN);
      owner_q   <= owner_nxt;

      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end

      // Counters restart on every state change and saturate rather than wrap
      if (state_nxt != state) begin
        hold_cnt <= '0;
      end else if ((state == ST_SPI_OWN || state == ST_I2C_OWN) && hold_cnt != '1) begin
        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
      end

      if (state_nxt != state) begin
        gap_cnt <= '0;
      end else if (state == ST_GAP && gap_cnt != '1) begin
        gap_cnt <= gap_cnt + GAP_CNT_W'(1);
      end

      if (state == ST_IDLE && state_nxt == ST_SPI_OWN) begin
        last_i2c <= 1'b0;
      end else if (state == ST_IDLE && state_nxt == ST_I2C_OWN) begin
        last_i2c <= 1'b1;
      end
    end
  end

  assign spi_pins = '{
    sclk:     sb.spi_sclk,
    cs_n:     sb.spi_cs_n,
    sdat_out: sb.spi_sdo,
    sdat_oe:  sb.spi_sdo_oe
  };

  // I2C has no chip select; keep the G-sensor deselected while I2C owns the bus
  assign i2c_pins = '{
    sclk:     sb.i2c_scl,
    cs_n:     IDLE_CS_N,
    sdat_out: sb.i2c_sda_out,
    sdat_oe:  sb.i2c_sda_oe
  };

  sensor_bus_pin_mux u_pin_mux (
    .owner    (owner_q),
    .spi_pins (spi_pins),
    .i2c_pins (i2c_pins),
    .bus_pins (bus_pins)
  );

  assign sb.bus_sclk     = bus_pins.sclk;
  assign sb.bus_cs_n     = bus_pins.cs_n;
  assign sb.bus_sdat_out = bus_pins.sdat_out;
  assign sb.bus_sdat_oe  = bus_pins.sdat_oe;
  assign sb.spi_sdi      = sb.bus_sdat_in;
  assign sb.i2c_sda_in   = sb.bus_sdat_in;
  assign sb.spi_gnt      = spi_gnt_q;
  assign sb.i2c_gnt      = i2c_gnt_q;
  assign sb.owner        = owner_q;
  assign sb.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_shared_sensor_bus_arbiter.sv
// Bench for shared_sensor_bus_arbiter: an edge-timestamp model of ownership,
// checked against the DUT every cycle, plus directed scenarios with literal
// expectations. GAP_CYCLES = 8, TIMEOUT_CYCLES = 100.
module tb_shared_sensor_bus_arbiter;

  localparam int GAP = 8;
  localparam int TO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  shared_sensor_bus_arbiter_if sb ();

  shared_sensor_bus_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk (clk),
    .reset   (rst),
    .sb      (sb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, the edge it was granted at, and the earliest edge
  // a new grant may happen (release edge + GAP + 1).
  int cyc        = 0;
  int own_m      = 0;   // 0 none, 1 SPI, 2 I2C
  int grant_edge = 0;
  int earliest   = 0;
  int last_m     = 2;
  bit err_m      = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own_m    = 0;
      last_m   = 2;
      err_m    = 1'b0;
      earliest = cyc;
    end else begin
      cyc++;
      if (own_m == 1) begin
        if (sb.spi_done || !sb.spi_req) begin
          own_m = 0; earliest = cyc + GAP + 1;
        end else if (cyc - grant_edge == TO) begin
          own_m = 0; earliest = cyc + GAP + 1; err_m = 1'b1;
        end
      end else if (own_m == 2) begin
        if (sb.i2c_done || !sb.i2c_req) begin
          own_m = 0; earliest = cyc + GAP + 1;
        end else if (cyc - grant_edge == TO) begin
          own_m = 0; earliest = cyc + GAP + 1; err_m = 1'b1;
        end
      end else if (cyc >= earliest) begin
        if (sb.spi_req && sb.i2c_req) own_m = (last_m == 2) ? 1 : 2;
        else if (sb.spi_req)          own_m = 1;
        else if (sb.i2c_req)          own_m = 2;
        if (own_m != 0) begin
          grant_edge = cyc;
          last_m     = own_m;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [3:0] ep;  // {sclk, cs_n, sdat_out, sdat_oe}
    if (own_m == 1)      ep = {sb.spi_sclk, sb.spi_cs_n, sb.spi_sdo, sb.spi_sdo_oe};
    else if (own_m == 2) ep = {sb.i2c_scl, 1'b1, sb.i2c_sda_out, sb.i2c_sda_oe};
    else                 ep = 4'b1110;
    chk("m_spi_gnt", 16'(sb.spi_gnt), 16'(own_m == 1));
    chk("m_i2c_gnt", 16'(sb.i2c_gnt), 16'(own_m == 2));
    chk("m_owner", 16'(sb.owner), 16'(own_m));
    chk("m_timeout_err", 16'(sb.timeout_err), 16'(err_m));
    chk("m_pins", 16'({sb.bus_sclk, sb.bus_cs_n, sb.bus_sdat_out, sb.bus_sdat_oe}), 16'(ep));
    chk("m_sdi", 16'({sb.spi_sdi, sb.i2c_sda_in}), 16'({sb.bus_sdat_in, sb.bus_sdat_in}));
    chk("m_excl", 16'(sb.spi_gnt & sb.i2c_gnt), 16'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sb.bus_sdat_in = ~sb.bus_sdat_in;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_spi_gnt", 16'(sb.spi_gnt), 16'd0);
    chk("rst_owner", 16'(sb.owner), 16'd0);
    chk("rst_err", 16'(sb.timeout_err), 16'd0);
    #3 rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    sb.spi_req = 0; sb.i2c_req = 0; sb.spi_done = 0; sb.i2c_done = 0;
    sb.spi_sclk = 1; sb.spi_cs_n = 1; sb.spi_sdo = 1; sb.spi_sdo_oe = 0;
    sb.i2c_scl = 1; sb.i2c_sda_out = 1; sb.i2c_sda_oe = 0; sb.bus_sdat_in = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 16'({sb.spi_gnt, sb.i2c_gnt}), 16'd0);
    chk("reset_owner", 16'(sb.owner), 16'd0);
    chk("reset_pins", 16'({sb.bus_sclk, sb.bus_cs_n, sb.bus_sdat_out, sb.bus_sdat_oe}), 16'b1110);
    chk("reset_err", 16'(sb.timeout_err), 16'd0);
    #2 rst = 1'b0;
    tick();

    // SPI-only transaction: grant for 20 cycles, cs_n follows the master
    sb.spi_req = 1;
    tick();
    chk("spi_first_gnt", 16'(sb.spi_gnt), 16'd1);
    chk("spi_first_owner", 16'(sb.owner), 16'd1);
    for (int i = 2; i <= 20; i++) begin
      sb.spi_cs_n = i[0];
      sb.spi_sdo_oe = ~i[0];
      #1;
      chk("spi_cs_follow", 16'(sb.bus_cs_n), 16'(i[0]));
      tick();
      chk("spi_gnt_held", 16'(sb.spi_gnt), 16'd1);
    end
    sb.spi_done = 1; sb.spi_req = 0;
    tick();
    sb.spi_done = 0; sb.spi_cs_n = 0; sb.spi_sdo_oe = 1;
    #1;
    chk("spi_release_owner", 16'(sb.owner), 16'd0);
    chk("spi_release_pins", 16'({sb.bus_cs_n, sb.bus_sdat_oe}), 16'b10);
    repeat (12) tick();
    sb.spi_cs_n = 1; sb.spi_sdo_oe = 0;

    // Simultaneous requests after reset: SPI first, I2C GAP+1 cycles after release
    do_reset();
    sb.spi_req = 1; sb.i2c_req = 1;
    sb.i2c_scl = 0; sb.i2c_sda_oe = 1; sb.i2c_sda_out = 0;
    tick();
    chk("rr_spi_first", 16'({sb.spi_gnt, sb.i2c_gnt}), 16'b10);
    repeat (5) tick();
    sb.spi_done = 1; sb.spi_req = 0;
    tick();
    sb.spi_done = 0;
    chk("rr_spi_released", 16'(sb.spi_gnt), 16'd0);
    n = 0;
    do begin
      tick();
      n++;
      if (!sb.i2c_gnt) chk("gap_oe_idle", 16'(sb.bus_sdat_oe), 16'd0);
    end while (!sb.i2c_gnt && n < 30);
    chk("rr_turnaround", 16'(n), 16'(GAP + 1));

    // Isolation: SPI intent changes never reach the pins while I2C owns them
    for (int i = 0; i < 6; i++) begin
      logic [2:0] v;
      v = 3'(i);
      sb.spi_sclk = v[0]; sb.spi_sdo_oe = ~v[0]; sb.spi_cs_n = 0;
      sb.i2c_scl = v[1];
      #1;
      chk("iso_sclk", 16'(sb.bus_sclk), 16'(v[1]));
      chk("iso_cs_n", 16'(sb.bus_cs_n), 16'd1);
      tick();
    end
    sb.spi_cs_n = 1; sb.spi_sdo_oe = 0;
    sb.i2c_done = 1; sb.i2c_req = 0;
    tick();
    sb.i2c_done = 0;
    chk("iso_release", 16'(sb.i2c_gnt), 16'd0);
    repeat (10) tick();

    // Timeout: I2C held with no done; pending SPI served after the gap
    sb.i2c_req = 1;
    tick();
    chk("to_i2c_gnt", 16'(sb.i2c_gnt), 16'd1);
    sb.spi_req = 1;
    n = 1;
    do begin
      tick();
      if (sb.i2c_gnt) n++;
    end while (sb.i2c_gnt && n < 150);
    chk("to_hold_cycles", 16'(n), 16'(TO));
    chk("to_err_set", 16'(sb.timeout_err), 16'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sb.spi_gnt && n < 30);
    chk("to_spi_after_gap", 16'(n), 16'(GAP + 1));
    chk("to_err_sticky", 16'(sb.timeout_err), 16'd1);
    sb.spi_done = 1; sb.spi_req = 0; sb.i2c_req = 0;
    tick();
    sb.spi_done = 0;
    repeat (12) tick();
    chk("to_err_still", 16'(sb.timeout_err), 16'd1);

    // Done coinciding with timeout: done wins, no error
    do_reset();
    sb.i2c_req = 1;
    tick();
    chk("col_gnt", 16'(sb.i2c_gnt), 16'd1);
    repeat (TO - 1) tick();
    chk("col_still_gnt", 16'(sb.i2c_gnt), 16'd1);
    sb.i2c_done = 1;
    tick();
    sb.i2c_done = 0; sb.i2c_req = 0;
    chk("col_released", 16'(sb.i2c_gnt), 16'd0);
    chk("col_no_err", 16'(sb.timeout_err), 16'd0);
    repeat (12) tick();

    // Asynchronous reset during SPI ownership, then immediate re-grant
    sb.spi_req = 1; sb.spi_cs_n = 0; sb.spi_sdo_oe = 1;
    tick();
    chk("ar_gnt", 16'(sb.spi_gnt), 16'd1);
    chk("ar_cs_n_low", 16'(sb.bus_cs_n), 16'd0);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt_drop", 16'(sb.spi_gnt), 16'd0);
    chk("ar_cs_n", 16'(sb.bus_cs_n), 16'd1);
    chk("ar_oe", 16'(sb.bus_sdat_oe), 16'd0);
    #3 rst = 1'b0;
    tick();
    chk("ar_regrant", 16'(sb.spi_gnt), 16'd1);
    sb.spi_req = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
